// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic units.
// FSM encodings and counter sizing helper.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must hold 0..WIDTH so the last increment never wraps
   function automatic int cnt_width(input int width);
      if (width < 1)
         return 1;
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Sequencer-facing handshake and operand bus
// for the bit-serial subtractor.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;

   modport master (
      output start,
      output a,
      output b,
      input  busy,
      input  done,
      input  diff,
      input  borrow
   );

   modport slave (
      input  start,
      input  a,
      input  b,
      output busy,
      output done,
      output diff,
      output borrow
   );

endinterface

// File: rtl/serial_subtractor_fs.sv
// One-bit subtractor cells: half subtractor and
// a full subtractor built from two of them.
module half_subtractor (
   input  logic a,
   input  logic b,
   output logic d,
   output logic bout
);

   assign d    = a ^ b;
   assign bout = ~a & b;

endmodule

module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic d1;
   logic b1;
   logic b2;

   half_subtractor u_hs0 (
      .a    (a),
      .b    (b),
      .d    (d1),
      .bout (b1)
   );

   half_subtractor u_hs1 (
      .a    (d1),
      .b    (bin),
      .d    (d),
      .bout (b2)
   );

   assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first,
// one full-subtractor cell per clock.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic          clk,
   input logic          rst_n,
   serial_subtractor_if.slave bus
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] d_sr;
   logic [WIDTH-1:0] d_next;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_q;
   logic             bin_q;
   logic [CW-1:0]    cnt_q;
   logic             load;
   logic             step;
   logic             last;
   logic             busy_c;
   logic             done_c;
   logic             fs_d;
   logic             fs_bout;

   full_subtractor u_fs (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (bin_q),
      .d    (fs_d),
      .bout (fs_bout)
   );

   assign last = (cnt_q == CW'(WIDTH - 1));

   // New bit enters at the MSB; written as shifts so WIDTH=1 stays legal
   assign d_next = (d_sr >> 1)
                 | (WIDTH'(fs_d) << (WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      busy_c  = 1'b0;
      done_c  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               load    = 1'b1;
            end
         end
         RUN: begin
            busy_c = 1'b1;
            step   = 1'b1;
            if (last)
               state_d = DONE;
         end
         DONE: begin
            done_c = 1'b1;
            if (bus.start) begin
               state_d = RUN;
               load    = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr     <= '0;
         b_sr     <= '0;
         d_sr     <= '0;
         bin_q    <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else if (load) begin
         a_sr  <= bus.a;
         b_sr  <= bus.b;
         d_sr  <= '0;
         bin_q <= 1'b0;
         cnt_q <= '0;
      end else if (step) begin
         a_sr  <= a_sr >> 1;
         b_sr  <= b_sr >> 1;
         d_sr  <= d_next;
         bin_q <= fs_bout;
         cnt_q <= cnt_q + CW'(1);
         // Visible result changes only when an operation completes
         if (last) begin
            diff_q   <= d_next;
            borrow_q <= fs_bout;
         end
      end
   end

   assign bus.busy   = busy_c;
   assign bus.done   = done_c;
   assign bus.diff   = diff_q;
   assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor:
// directed vectors, done-driven result monitor.
module tb_serial_subtractor;

   localparam int W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   serial_subtractor_if #(.WIDTH(W)) sif ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sif)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] dv;
      logic         bv;
   } exp_t;

   exp_t         sb[$];
   exp_t         e;
   int           n_chk = 0;
   int           n_fail = 0;
   int           cyc = 0;
   int           dones = 0;
   int           done_at[$];
   logic [W-1:0] last_diff = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sif.done === 1'b1) begin
         dones++;
         done_at.push_back(cyc);
         chk("sb_nonempty",
             64'(sb.size() != 0), 64'(1));
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("diff", 64'(sif.diff), 64'(e.dv));
            chk("borrow", 64'(sif.borrow), 64'(e.bv));
            last_diff = e.dv;
         end
      end
   end

   task automatic do_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [W-1:0] ed,
                        input logic         eb);
      int nb = 0;
      bit seen = 1'b0;
      @(posedge clk); #1;
      sif.start = 1'b1;
      sif.a     = a;
      sif.b     = b;
      sb.push_back('{dv: ed, bv: eb});
      @(posedge clk); #1;
      sif.start = 1'b0;
      sif.a     = ~a;
      sif.b     = ~b;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (sif.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (sif.busy === 1'b1) begin
            if (nb == 0)
               chk("diff_hold_run",
                   64'(sif.diff), 64'(last_diff));
            nb++;
         end
      end
      chk("done_seen", 64'(seen), 64'(1));
      chk("busy_cycles", 64'(nb), 64'(W));
   endtask

   task automatic wait_done(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (sif.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int d0;
      int k;
      bit seen;
      sif.start = 1'b0;
      sif.a     = '0;
      sif.b     = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      repeat (20) begin
         @(negedge clk);
         chk("rst_busy", 64'(sif.busy), 64'(0));
         chk("rst_done", 64'(sif.done), 64'(0));
         chk("rst_diff", 64'(sif.diff), 64'(0));
         chk("rst_borrow", 64'(sif.borrow), 64'(0));
      end

      do_op(8'd100, 8'd37, 8'd63, 1'b0);
      do_op(8'd5,   8'd9,  8'hFC, 1'b1);
      do_op(8'h00,  8'h01, 8'hFF, 1'b1);
      do_op(8'hFF,  8'hFF, 8'h00, 1'b0);
      do_op(8'hFF,  8'h00, 8'hFF, 1'b0);

      repeat (5) @(negedge clk);
      chk("diff_hold_idle", 64'(sif.diff), 64'hFF);

      // start pulses during RUN are ignored
      d0 = dones;
      @(posedge clk); #1;
      sif.start = 1'b1;
      sif.a     = 8'h50;
      sif.b     = 8'h10;
      sb.push_back('{dv: 8'h40, bv: 1'b0});
      @(posedge clk); #1 sif.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      sif.start = 1'b1;
      sif.a     = 8'h01;
      sif.b     = 8'h02;
      @(posedge clk); #1 sif.start = 1'b0;
      @(posedge clk); #1 sif.start = 1'b1;
      @(posedge clk); #1 sif.start = 1'b0;
      wait_done(seen);
      chk("busy_start_done", 64'(seen), 64'(1));
      repeat (12) @(negedge clk);
      chk("busy_start_ndone", 64'(dones - d0), 64'(1));

      // start held high: back-to-back operations
      repeat (3) sb.push_back('{dv: 8'hF6, bv: 1'b1});
      d0 = done_at.size();
      k  = 0;
      @(posedge clk); #1;
      sif.start = 1'b1;
      sif.a     = 8'd20;
      sif.b     = 8'd30;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (sif.done === 1'b1) begin
            k++;
            if (k == 3) begin
               sif.start = 1'b0;
               break;
            end
         end
      end
      #1;
      chk("b2b_count", 64'(k), 64'(3));
      if (done_at.size() >= d0 + 3) begin
         chk("b2b_period1",
             64'(done_at[d0+1] - done_at[d0]), 64'(9));
         chk("b2b_period2",
             64'(done_at[d0+2] - done_at[d0+1]), 64'(9));
      end
      repeat (12) @(negedge clk);
      chk("b2b_stop", 64'(done_at.size() - d0), 64'(3));

      // reset in the middle of an operation
      d0 = dones;
      @(posedge clk); #1;
      sif.start = 1'b1;
      sif.a     = 8'd9;
      sif.b     = 8'd3;
      @(posedge clk); #1 sif.start = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_busy", 64'(sif.busy), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 64'(sif.busy), 64'(0));
      chk("abort_done", 64'(sif.done), 64'(0));
      chk("abort_diff", 64'(sif.diff), 64'(0));
      chk("abort_borrow", 64'(sif.borrow), 64'(0));
      last_diff = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("abort_ndone", 64'(dones - d0), 64'(0));

      do_op(8'd200, 8'd55, 8'd145, 1'b0);
      do_op(8'h80,  8'h81, 8'hFF,  1'b1);

      repeat (3) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
